// File: rtl/apb_codec_block.sv
// APB slave wrapping a one-hot decoder and a priority encoder.
// Input, control, result and status are register-mapped.
module apb_codec_block #(
    parameter int IN_W        = 3,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int OUT_W = 2 ** IN_W;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    if (DATA_W < OUT_W) begin : g_bad_width
        $error("apb_codec_block: DATA_W must be >= 2**IN_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q, rdy_d;

    logic [1:0]       ctrl_q;
    logic [OUT_W-1:0] din_q;
    logic [OUT_W-1:0] dout_q;
    logic [1:0]       stat_q;
    logic             upd_q;

    logic [OUT_W-1:0] res;
    logic [1:0]       st;
    logic [IN_W-1:0]  pidx;
    logic [DATA_W-1:0] rdata;

    logic setup_ph, access_ph, done, err, wr_commit;
    logic a_ctrl, a_din, a_dout, a_stat;
    logic unused_ok;

    assign unused_ok = ^pwdata;

    assign setup_ph  = psel & ~penable;
    assign access_ph = psel & penable;

    assign a_ctrl = (paddr == ADDR_W'(8'h00));
    assign a_din  = (paddr == ADDR_W'(8'h04));
    assign a_dout = (paddr == ADDR_W'(8'h08));
    assign a_stat = (paddr == ADDR_W'(8'h0C));

    assign err = ~(a_ctrl | a_din | a_dout | a_stat)
               | (pwrite & (a_dout | a_stat));

    // rdy_q is only ever set in ACCESS; gating with the bus hides
    // the pulse if the master abandons the transfer.
    assign done      = rdy_q & access_ph;
    assign wr_commit = done & pwrite & ~err;

    assign pready  = done;
    assign pslverr = done & err;
    assign prdata  = (done & ~err & ~pwrite) ? rdata : '0;

    // Read data mux over the four mapped registers.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            a_ctrl:  rdata = DATA_W'(ctrl_q);
            a_din:   rdata = DATA_W'(din_q);
            a_dout:  rdata = DATA_W'(dout_q);
            a_stat:  rdata = DATA_W'(stat_q);
            default: rdata = '0;
        endcase
    end

    // Bus FSM state, wait counter and ready registers.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next state: setup seen -> ACCESS, count waits, then one ready cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup_ph) begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                    rdy_d   = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!access_ph) begin
                    cnt_d = '0;
                    if (setup_ph) begin
                        state_d = ACCESS;
                        rdy_d   = (WAIT_STATES == 0);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (rdy_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    rdy_d = (cnt_d == CW'(WAIT_STATES));
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register writes, and result capture one edge after a write.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_q <= '0;
            din_q  <= '0;
            dout_q <= '0;
            stat_q <= '0;
            upd_q  <= 1'b0;
        end else begin
            if (wr_commit && a_ctrl) ctrl_q <= pwdata[1:0];
            if (wr_commit && a_din)  din_q  <= pwdata[OUT_W-1:0];
            upd_q <= wr_commit;
            if (upd_q) begin
                dout_q <= res;
                stat_q <= st;
            end
        end
    end

    // Decode / priority-encode of the current DIN under CTRL.
    always_comb begin
        res  = '0;
        st   = '0;
        pidx = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (din_q[i]) pidx = IN_W'(i);
        end
        if (ctrl_q[0]) begin
            if (!ctrl_q[1]) begin
                res[din_q[IN_W-1:0]] = 1'b1;
                st = 2'b01;
            end else begin
                res = OUT_W'(pidx);
                st  = {|(din_q & (din_q - OUT_W'(1))), |din_q};
            end
        end
    end

endmodule

// File: tb/tb_apb_codec_block.sv
// Scoreboard bench: two DUT builds (IN_W=3/WS=1, IN_W=4/WS=0)
// checked against a behavioural model of the register map.
module tb_apb_codec_block;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        chk;
        string       name;
    } exp_t;

    logic        pclk;
    logic        preset  [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [7:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    int checks   = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q1[$];

    int mctrl[2];
    int mdin[2];

    apb_codec_block #(.IN_W(3), .DATA_W(32), .ADDR_W(8), .WAIT_STATES(1)) u0 (
        .pclk(pclk), .preset(preset[0]), .psel(psel[0]),
        .penable(penable[0]), .pwrite(pwrite[0]), .paddr(paddr[0]),
        .pwdata(pwdata[0]), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0])
    );

    apb_codec_block #(.IN_W(4), .DATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) u1 (
        .pclk(pclk), .preset(preset[1]), .psel(psel[1]),
        .penable(penable[1]), .pwrite(pwrite[1]), .paddr(paddr[1]),
        .pwdata(pwdata[1]), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int out_w(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int ws(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Result as the register map defines it, from model CTRL/DIN.
    function automatic logic [31:0] model_dout(input int d);
        if ((mctrl[d] & 1) == 0) return 32'h0;
        if ((mctrl[d] & 2) == 0) return 32'h1 << (mdin[d] % out_w(d));
        for (int i = out_w(d) - 1; i >= 0; i--)
            if (((mdin[d] >> i) & 1) != 0) return i;
        return 32'h0;
    endfunction

    function automatic logic [31:0] model_status(input int d);
        int ones;
        if ((mctrl[d] & 1) == 0) return 32'h0;
        if ((mctrl[d] & 2) == 0) return 32'h1;
        ones = $countones(mdin[d]);
        return ((ones > 1) ? 32'h2 : 32'h0) | ((ones > 0) ? 32'h1 : 32'h0);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [7:0] a);
        case (a)
            8'h00:   return mctrl[d];
            8'h04:   return mdin[d];
            8'h08:   return model_dout(d);
            8'h0C:   return model_status(d);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_resp(input int d, input exp_t e);
        checks++;
        if (pslverr[d] !== e.err || (e.chk && prdata[d] !== e.data)) begin
            failures++;
            $display("FAIL dut%0d %s: got data=%h err=%b, want data=%h err=%b",
                     d, e.name, prdata[d], pslverr[d], e.data, e.err);
        end
    endtask

    task automatic chk_val(input string nm, input logic [31:0] got,
                           input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Monitors: pop one expectation per pready cycle.
    always @(negedge pclk) begin
        if (preset[0] === 1'b0 && pready[0] === 1'b1) begin
            if (q0.size() == 0) chk_val("dut0 unexpected pready", 1, 0);
            else check_resp(0, q0.pop_front());
        end
    end

    always @(negedge pclk) begin
        if (preset[1] === 1'b0 && pready[1] === 1'b1) begin
            if (q1.size() == 0) chk_val("dut1 unexpected pready", 1, 0);
            else check_resp(1, q1.pop_front());
        end
    end

    task automatic model_reset(input int d);
        mctrl[d] = 0;
        mdin[d]  = 0;
    endtask

    // One full transfer; leaves the bus ready for a back-to-back follow-on.
    task automatic xfer(input int d, input bit w, input logic [7:0] a,
                        input logic [31:0] v, input string nm);
        exp_t e;
        int   n;
        bit   hit;
        hit    = (a == 8'h00) || (a == 8'h04) || (a == 8'h08) || (a == 8'h0C);
        e.err  = !hit || (w && (a == 8'h08 || a == 8'h0C));
        e.chk  = !w;
        e.name = nm;
        e.data = (e.err || w) ? 32'h0 : model_read(d, a);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (w && !e.err) begin
            if (a == 8'h00) mctrl[d] = v & 3;
            else            mdin[d]  = v & ((1 << out_w(d)) - 1);
        end
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = w;
        paddr[d]   = a;
        pwdata[d]  = v;
        @(posedge pclk);
        #1 penable[d] = 1'b1;
        n = 0;
        forever begin
            @(negedge pclk);
            n++;
            if (pready[d] === 1'b1 || n > 20) break;
        end
        chk_val($sformatf("dut%0d %s access cycles", d, nm), n, ws(d) + 1);
        @(posedge pclk);
        #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(posedge pclk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            preset[d]  = 1'b1;
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            pwrite[d]  = 1'b0;
            paddr[d]   = '0;
            pwdata[d]  = '0;
            model_reset(d);
        end
        idle(3);
        for (int d = 0; d < 2; d++) begin
            chk_val($sformatf("dut%0d reset pready", d), pready[d], 0);
            chk_val($sformatf("dut%0d reset prdata", d), prdata[d], 0);
            chk_val($sformatf("dut%0d reset pslverr", d), pslverr[d], 0);
        end
        preset[0] = 1'b0;
        preset[1] = 1'b0;
        idle(2);

        xfer(0, 0, 8'h00, 0, "rst CTRL");
        xfer(0, 0, 8'h04, 0, "rst DIN");
        xfer(0, 0, 8'h08, 0, "rst DOUT");
        xfer(0, 0, 8'h0C, 0, "rst STATUS");

        xfer(0, 1, 8'h00, 32'h1, "wr CTRL dec");
        for (int v = 0; v < 8; v++) begin
            xfer(0, 1, 8'h04, v, "wr DIN");
            xfer(0, 0, 8'h08, 0, $sformatf("dec DOUT din=%0d", v));
            xfer(0, 0, 8'h0C, 0, "dec STATUS");
        end

        xfer(0, 1, 8'h00, 32'h3, "wr CTRL pri");
        xfer(0, 1, 8'h04, 32'h28, "wr DIN 28");
        xfer(0, 0, 8'h08, 0, "pri DOUT 28");
        xfer(0, 0, 8'h0C, 0, "pri STATUS 28");
        xfer(0, 1, 8'h04, 32'h01, "wr DIN 01");
        xfer(0, 0, 8'h08, 0, "pri DOUT 01");
        xfer(0, 0, 8'h0C, 0, "pri STATUS 01");
        xfer(0, 1, 8'h04, 32'h00, "wr DIN 00");
        xfer(0, 0, 8'h08, 0, "pri DOUT 00");
        xfer(0, 0, 8'h0C, 0, "pri STATUS 00");

        xfer(0, 1, 8'h04, 32'h30, "wr DIN 30");
        xfer(0, 0, 8'h10, 0, "rd unmapped 10");
        xfer(0, 0, 8'h02, 0, "rd unaligned 02");
        xfer(0, 1, 8'h08, 32'hFF, "wr RO DOUT");
        xfer(0, 1, 8'h0C, 32'hFF, "wr RO STATUS");
        xfer(0, 0, 8'h08, 0, "DOUT after err");
        idle(1);

        // Master abandons a DIN write in its wait cycle.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 8'h04; pwdata[0] = 32'h99;
        @(posedge pclk);
        #1 penable[0] = 1'b1;
        @(negedge pclk);
        chk_val("abort wait pready", pready[0], 0);
        @(posedge pclk);
        #1 psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge pclk);
        chk_val("abort no pready", pready[0], 0);
        idle(1);
        xfer(0, 0, 8'h04, 0, "DIN after abort");
        idle(1);

        // Reset lands in the wait cycle of a DIN write.
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
        paddr[0] = 8'h04; pwdata[0] = 32'h40;
        @(posedge pclk);
        #1 penable[0] = 1'b1;
        @(negedge pclk);
        preset[0] = 1'b1;
        model_reset(0);
        #1;
        chk_val("midrst pready", pready[0], 0);
        chk_val("midrst prdata", prdata[0], 0);
        chk_val("midrst pslverr", pslverr[0], 0);
        @(posedge pclk);
        #1 psel[0] = 1'b0; penable[0] = 1'b0;
        @(negedge pclk);
        chk_val("midrst pready held", pready[0], 0);
        @(posedge pclk);
        #1 preset[0] = 1'b0;
        idle(1);
        xfer(0, 0, 8'h04, 0, "DIN after midrst");
        xfer(0, 0, 8'h08, 0, "DOUT after midrst");
        xfer(0, 0, 8'h00, 0, "CTRL after midrst");

        xfer(1, 1, 8'h00, 32'h1, "wr CTRL dec");
        xfer(1, 1, 8'h04, 32'd15, "wr DIN 15");
        xfer(1, 0, 8'h08, 0, "dec DOUT 15");
        xfer(1, 1, 8'h00, 32'h3, "wr CTRL pri");
        xfer(1, 1, 8'h04, 32'h8001, "wr DIN 8001");
        xfer(1, 0, 8'h08, 0, "pri DOUT 8001");
        xfer(1, 0, 8'h0C, 0, "pri STATUS 8001");

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 150; k++) begin
                int r;
                logic [7:0]  a;
                logic [31:0] v;
                r = $urandom_range(0, 5);
                if (r < 4)       a = 8'(r * 4);
                else if (r == 4) a = 8'($urandom_range(0, 255));
                else             a = 8'(($urandom_range(0, 3) * 4) + $urandom_range(1, 3));
                v = $urandom;
                if (a == 8'h04 && $urandom_range(0, 1) == 1)
                    v = 32'h1 << $urandom_range(0, 31);
                xfer(d, 1'($urandom_range(0, 1)), a, v, "rand");
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end

        idle(4);
        chk_val("dut0 queue drained", q0.size(), 0);
        chk_val("dut1 queue drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
